// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns a controller request into a single req/ack
// data-memory transaction and returns the extended load result.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] load_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    if (WIDTH != 32) begin : g_width_check
        $error("load_store_unit supports WIDTH=32 only");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] load_data_q, load_data_d;
    logic [3:0]       mem_be_q, mem_be_d;

    logic             illegal, misaligned;
    logic [WIDTH-1:0] lane;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        load_data_d = load_data_q;

        illegal    = is_store ? (funct3 >= 3'd3)
                              : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
        misaligned = (funct3[1:0] == 2'd1 && addr[0]) ||
                     (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00);

        // LW is always word aligned, so the shifted word doubles as its result.
        lane = mem_rdata >> {addr_lo_q, 3'b000};

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    err_d      = illegal || misaligned;
                    mem_addr_d = {addr[WIDTH-1:2], 2'b00};
                    case (funct3[1:0])
                        2'd0: begin
                            mem_be_d    = 4'b0001 << addr[1:0];
                            mem_wdata_d = {4{store_data[7:0]}};
                        end
                        2'd1: begin
                            mem_be_d    = 4'b0011 << {addr[1], 1'b0};
                            mem_wdata_d = {2{store_data[15:0]}};
                        end
                        default: begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = store_data;
                        end
                    endcase
                    state_d = (illegal || misaligned) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!is_store_q) begin
                        case (funct3_q)
                            3'd0:    load_data_d = {{(WIDTH-8){lane[7]}}, lane[7:0]};
                            3'd1:    load_data_d = {{(WIDTH-16){lane[15]}}, lane[15:0]};
                            3'd4:    load_data_d = {{(WIDTH-8){1'b0}}, lane[7:0]};
                            3'd5:    load_data_d = {{(WIDTH-16){1'b0}}, lane[15:0]};
                            default: load_data_d = lane;
                        endcase
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            load_data_q <= load_data_d;
        end
    end

    // Status outputs decode straight from the state so reset clears them at once.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == RESP);
    assign fault     = done && err_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected memory
// transactions and responses; independent monitors compare what the DUT presents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        fault;
        logic [31:0] load_data;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int          checks   = 0;
    int          failures = 0;
    int          ack_delay_cfg = 0;
    logic [31:0] rdata_cfg = '0;

    load_store_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay_cfg wait cycles and checks the request.
    initial begin
        int   wait_cnt = 0;
        req_t r;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_mem_req", 32'(mem_req), 32'h0);
                end else begin
                    r = req_q[0];
                    check("mem_we",   32'(mem_we), 32'(r.we));
                    check("mem_addr", mem_addr,    r.addr);
                    check("mem_be",   32'(mem_be), 32'(r.be));
                    if (r.we) check("mem_wdata", mem_wdata, r.wdata);
                    if (wait_cnt == ack_delay_cfg) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rdata_cfg;
                        void'(req_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Response monitor: every done pulse consumes one expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = resp_q.pop_front();
                    check("fault",     32'(fault), 32'(e.fault));
                    check("load_data", load_data,  e.load_data);
                end
            end
        end
    end

    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int dly, input logic exp_fault, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld,
                          input int exp_lat, input int extra_at);
        int cycles;
        int busy_cycles;
        req_t  r;
        resp_t e;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'h0);
        if (!exp_fault) begin
            r.we = st; r.addr = {a[31:2], 2'b00}; r.be = exp_be; r.wdata = exp_wd;
            req_q.push_back(r);
        end
        e.fault = exp_fault; e.load_data = exp_ld;
        resp_q.push_back(e);
        ack_delay_cfg = dly;
        rdata_cfg     = rd;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        cycles = 0; busy_cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            start = (cycles == extra_at);
            if (start) addr = 32'h0000_0999;
            if (busy) busy_cycles++;
        end while (!done && cycles < 50);
        start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    endtask

    initial begin
        resp_t e;
        req_t  r;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = '0; store_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy),    32'h0);
        check("rst_done",      32'(done),    32'h0);
        check("rst_fault",     32'(fault),   32'h0);
        check("rst_mem_req",   32'(mem_req), 32'h0);
        check("rst_mem_we",    32'(mem_we),  32'h0);
        check("rst_mem_be",    32'(mem_be),  32'h0);
        check("rst_mem_addr",  mem_addr,     32'h0);
        check("rst_mem_wdata", mem_wdata,    32'h0);
        check("rst_load_data", load_data,    32'h0);
        rst_n = 1'b1;

        //       tag   st    f3    addr          store_data    rdata         dly flt be       wdata         load_data     lat extra
        access("lb",   1'b0, 3'd0, 32'h0000_0103, 32'h0,       32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,       32'hFFFF_FF80, 2, 0);
        access("lhu",  1'b0, 3'd5, 32'h0000_0102, 32'h0,       32'hBEEF_0000, 0, 1'b0, 4'b1100, 32'h0,       32'h0000_BEEF, 2, 0);
        access("lh",   1'b0, 3'd1, 32'h0000_0102, 32'h0,       32'hBEEF_0000, 1, 1'b0, 4'b1100, 32'h0,       32'hFFFF_BEEF, 3, 0);
        access("sb",   1'b1, 3'd0, 32'h0000_0021, 32'h1234_56A5, 32'h5555_5555, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_BEEF, 2, 0);
        access("sh",   1'b1, 3'd1, 32'h0000_0022, 32'h0000_CAFE, 32'h0,     1, 1'b0, 4'b1100, 32'hCAFE_CAFE, 32'hFFFF_BEEF, 3, 0);
        access("sw",   1'b1, 3'd2, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0,     0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_BEEF, 2, 0);
        access("lbu",  1'b0, 3'd4, 32'h0000_0001, 32'h0,       32'h0000_F700, 0, 1'b0, 4'b0010, 32'h0,       32'h0000_00F7, 2, 0);
        access("sw_mis", 1'b1, 3'd2, 32'h0000_0006, 32'h1111_2222, 32'h0,   0, 1'b1, 4'b0000, 32'h0,       32'h0000_00F7, 1, 0);
        access("ld_f3",  1'b0, 3'd3, 32'h0000_0000, 32'h0,     32'h0,       0, 1'b1, 4'b0000, 32'h0,       32'h0000_00F7, 1, 0);
        access("lh_mis", 1'b0, 3'd1, 32'h0000_0011, 32'h0,     32'h0,       0, 1'b1, 4'b0000, 32'h0,       32'h0000_00F7, 1, 0);
        access("st_f3",  1'b1, 3'd4, 32'h0000_0010, 32'h0,     32'h0,       0, 1'b1, 4'b0000, 32'h0,       32'h0000_00F7, 1, 0);
        access("lw_wait", 1'b0, 3'd2, 32'h0000_0040, 32'h0,    32'h1234_5678, 3, 1'b0, 4'b1111, 32'h0,     32'h1234_5678, 5, 2);

        // Reset in the middle of an ack wait aborts the transaction.
        @(negedge clk);
        r.we = 1'b0; r.addr = 32'h0000_0060; r.be = 4'b1111; r.wdata = '0;
        req_q.push_back(r);
        e.fault = 1'b0; e.load_data = 32'h0;
        resp_q.push_back(e);
        ack_delay_cfg = 20;
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0060;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_mem_req", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'h0);
        check("mid_rst_busy",    32'(busy),    32'h0);
        check("mid_rst_done",    32'(done),    32'h0);
        req_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        check("post_rst_load_data", load_data, 32'h0);
        rst_n = 1'b1;
        access("lw_after_rst", 1'b0, 3'd2, 32'h0000_0080, 32'h0, 32'hA5A5_5A5A, 0, 1'b0, 4'b1111, 32'h0, 32'hA5A5_5A5A, 2, 0);

        repeat (3) @(negedge clk);
        check("req_queue_drained",  32'(req_q.size()),  32'h0);
        check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
